// File: rtl/ucode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ucode_pkg
// Purpose  : Shared definitions for the Robertson multiplier microsequencer:
//            micro-address constants, branch conditions and microword layout.
// Revision : 1.0  initial release
// ============================================================================
package ucode_pkg;

  // Micro-addresses of the multiply routine
  localparam logic [4:0] IDLE   = 5'd0;
  localparam logic [4:0] LOAD   = 5'd1;
  localparam logic [4:0] TEST   = 5'd2;
  localparam logic [4:0] ADD    = 5'd3;
  localparam logic [4:0] SHIFT  = 5'd4;
  localparam logic [4:0] LOOP   = 5'd5;
  localparam logic [4:0] FTEST  = 5'd6;
  localparam logic [4:0] SUB    = 5'd7;
  localparam logic [4:0] FSHIFT = 5'd8;
  localparam logic [4:0] DONE   = 5'd9;
  localparam logic [4:0] RET    = 5'd10;

  // Branch condition: when true the micro-PC loads the target, else increments
  typedef enum logic [2:0] {
    INCR      = 3'd0,
    ALWAYS    = 3'd1,
    IF_NSTART = 3'd2,
    IF_START  = 3'd3,
    IF_Q0Z    = 3'd4,
    IF_CNTNZ  = 3'd5
  } cond_e;

  typedef struct packed {
    cond_e      cond;
    logic [4:0] target;
    logic       ld_m;
    logic       ld_q;
    logic       clr_a;
    logic       add_en;
    logic       sub_en;
    logic       shift_en;
    logic       done;
  } uword_t;

  // Microword with a branch field and every strobe deasserted
  function automatic uword_t uw_branch(input cond_e c, input logic [4:0] t);
    uword_t w;
    w          = '0;
    w.cond     = c;
    w.target   = t;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ucode_rom.sv
`default_nettype none
// ============================================================================
// Module   : ucode_rom
// Purpose  : Combinational micro-address to microword lookup. Addresses past
//            RET decode to an unconditional return to IDLE and flag illegal.
// Revision : 1.0  initial release
// ============================================================================
module ucode_rom
  import ucode_pkg::*;
(
  input  logic [4:0] upc_i,
  output uword_t     uword_o,
  output logic       illegal_o
);

  // Microcode table
  always_comb begin
    uword_o   = uw_branch(INCR, IDLE);
    illegal_o = 1'b0;
    case (upc_i)
      IDLE:   uword_o = uw_branch(IF_NSTART, IDLE);
      LOAD: begin
        uword_o.ld_m  = 1'b1;
        uword_o.ld_q  = 1'b1;
        uword_o.clr_a = 1'b1;
      end
      TEST:   uword_o = uw_branch(IF_Q0Z, SHIFT);
      ADD:    uword_o.add_en = 1'b1;
      SHIFT:  uword_o.shift_en = 1'b1;
      LOOP:   uword_o = uw_branch(IF_CNTNZ, TEST);
      FTEST:  uword_o = uw_branch(IF_Q0Z, FSHIFT);
      // Robertson sign correction: the multiplier MSB carries negative weight
      SUB:    uword_o.sub_en = 1'b1;
      FSHIFT: uword_o.shift_en = 1'b1;
      DONE: begin
        uword_o      = uw_branch(IF_START, DONE);
        uword_o.done = 1'b1;
      end
      RET:    uword_o = uw_branch(ALWAYS, IDLE);
      default: begin
        uword_o   = uw_branch(ALWAYS, IDLE);
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ucode_seq.sv
`default_nettype none
// ============================================================================
// Module   : ucode_seq
// Purpose  : Microsequencer for an N-bit Robertson signed multiplier. Decodes
//            the external micro-PC, evaluates the branch in the same cycle,
//            and owns the iteration counter and sticky illegal-address flag.
//            Legal N range is 2..16.
// Revision : 1.0  initial release
// ============================================================================
module ucode_seq
  import ucode_pkg::*;
#(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] upc,
  input  logic       start,
  input  logic       q0,
  output logic       load_incr,
  output logic [4:0] upc_next,
  output logic       ld_m,
  output logic       ld_q,
  output logic       clr_a,
  output logic       add_en,
  output logic       sub_en,
  output logic       shift_en,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

  uword_t        uw;
  logic          illegal;
  logic          take;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          err_q;
  logic          err_d;

  ucode_rom u_rom (
    .upc_i     (upc),
    .uword_o   (uw),
    .illegal_o (illegal)
  );

  // Branch decision from the microword condition and live status inputs
  always_comb begin
    take = 1'b0;
    case (uw.cond)
      INCR:      take = 1'b0;
      ALWAYS:    take = 1'b1;
      IF_NSTART: take = ~start;
      IF_START:  take = start;
      IF_Q0Z:    take = ~q0;
      IF_CNTNZ:  take = (cnt_q != '0);
      default:   take = 1'b0;
    endcase
  end

  // Target is forced to zero whenever the micro-PC is incrementing
  assign load_incr = take;
  assign upc_next  = take ? uw.target : 5'd0;

  assign ld_m     = uw.ld_m;
  assign ld_q     = uw.ld_q;
  assign clr_a    = uw.clr_a;
  assign add_en   = uw.add_en;
  assign sub_en   = uw.sub_en;
  assign shift_en = uw.shift_en;
  assign done     = uw.done;
  assign busy     = (upc != IDLE) && (upc != DONE);
  assign err      = err_q;

  // Counter loads N-1 at LOAD and counts loop shifts; the final shift is
  // outside the loop so N-1 loop passes give N shifts in total
  always_comb begin
    cnt_d = cnt_q;
    if (upc == LOAD) begin
      cnt_d = CNT_INIT;
    end else if (upc == SHIFT) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Illegal-address flag is sticky until reset
  always_comb begin
    err_d = err_q | illegal;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ucode_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ucode_seq
// Purpose  : Closed-loop bench: micro-PC and Robertson datapath models around
//            ucode_seq, scoreboard of expected products and timing.
// Revision : 1.0  initial release
// ============================================================================
module tb_ucode_seq;
  import ucode_pkg::*;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] upc;
  logic       start;
  logic       q0;
  logic       load_incr;
  logic [4:0] upc_next;
  logic       ld_m, ld_q, clr_a, add_en, sub_en, shift_en;
  logic       busy, done, err;

  ucode_seq #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .upc       (upc),
    .start     (start),
    .q0        (q0),
    .load_incr (load_incr),
    .upc_next  (upc_next),
    .ld_m      (ld_m),
    .ld_q      (ld_q),
    .clr_a     (clr_a),
    .add_en    (add_en),
    .sub_en    (sub_en),
    .shift_en  (shift_en),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // micro-PC register model, overridable for address forcing
  logic [4:0] upc_model;
  logic       force_en;
  logic [4:0] force_val;
  assign upc = force_en ? force_val : upc_model;

  always @(posedge clk or posedge reset) begin
    if (reset)          upc_model <= 5'd0;
    else if (load_incr) upc_model <= upc_next;
    else                upc_model <= upc_model + 5'd1;
  end

  // datapath model: A carries one guard bit so A+M never loses its sign
  logic signed [N:0] dp_a;
  logic [N-1:0]      dp_q, dp_m, m_in, q_in;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_a <= '0; dp_q <= '0; dp_m <= '0;
    end else begin
      if (ld_m)     dp_m <= m_in;
      if (ld_q)     dp_q <= q_in;
      if (clr_a)    dp_a <= '0;
      if (add_en)   dp_a <= dp_a + {dp_m[N-1], dp_m};
      if (sub_en)   dp_a <= dp_a - {dp_m[N-1], dp_m};
      if (shift_en) {dp_a, dp_q} <= {dp_a[N], dp_a, dp_q[N-1:1]};
    end
  end
  assign q0 = dp_q[0];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
  endtask

  typedef struct {
    logic [2*N-1:0] prod;
    int lat;
    int adds;
    int subs;
    int shifts;
  } exp_t;
  exp_t exp_q[$];

  // Reference: signed product plus cycle/strobe counts from the algorithm:
  // LOAD, then per low bit TEST(+ADD if 1)+SHIFT+LOOP, then FTEST(+SUB)+FSHIFT
  function automatic exp_t model(input logic [N-1:0] m, input logic [N-1:0] q);
    exp_t e;
    logic signed [2*N-1:0] sm, sq, p;
    sm = $signed(m);
    sq = $signed(q);
    p  = sm * sq;
    e.prod   = p;
    e.adds   = 0;
    for (int i = 0; i < N - 1; i++) e.adds += int'(q[i]);
    e.subs   = int'(q[N-1]);
    e.shifts = N;
    e.lat    = 1 + 3 * (N - 1) + e.adds + 2 + e.subs;
    return e;
  endfunction

  // Monitor: measures each operation from LOAD and scores it on done
  int viol = 0;
  initial begin
    bit in_op = 0;
    bit done_prev = 0;
    int cyc = 0, na = 0, ns = 0, nsh = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_op = 0;
        done_prev = 0;
      end else begin
        if (int'(add_en) + int'(sub_en) + int'(shift_en) > 1) viol++;
        if (upc == LOAD) begin
          in_op = 1; cyc = 0; na = 0; ns = 0; nsh = 0;
        end else if (in_op) begin
          cyc++;
        end
        if (in_op) begin
          na  += int'(add_en);
          ns  += int'(sub_en);
          nsh += int'(shift_en);
        end
        if (done && !done_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("product", 32'(dp_a[N-1:0]) << N | 32'(dp_q), 32'(e.prod));
            check("latency", cyc, e.lat);
            check("add_count", na, e.adds);
            check("sub_count", ns, e.subs);
            check("shift_count", nsh, e.shifts);
          end
          in_op = 0;
        end
        done_prev = done;
      end
    end
  end

  task automatic wait_upc(input logic [4:0] v, input int lim, input string nm);
    int k = 0;
    while (upc !== v && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(nm, 32'(upc), 32'(v));
  endtask

  // One closed-loop multiply with start held for `hold` cycles into DONE
  task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] q, input int hold);
    @(negedge clk);
    m_in = m;
    q_in = q;
    exp_q.push_back(model(m, q));
    start = 1'b1;
    wait_upc(DONE, 200, "reach_done");
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_upc_done", {27'd0, upc}, 32'(DONE));
      check("hold_done", 32'(done), 32'd1);
    end
    start = 1'b0;
    @(negedge clk);
    check("ret_after_done", 32'(upc), 32'(RET));
    @(negedge clk);
    check("idle_after_ret", 32'(upc), 32'(IDLE));
    repeat (3) @(negedge clk);
    check("no_retrigger", 32'(upc), 32'(IDLE));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    force_en  = 1'b0;
    force_val = 5'd0;
    m_in      = '0;
    q_in      = '0;
    repeat (2) @(negedge clk);
    check("reset_idle_decode", {28'd0, load_incr, busy, done, err}, 32'h8);
    reset = 1'b0;

    // Idle with start low
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_outputs", {24'd0, load_incr, upc_next, busy, done}, {24'd0, 1'b1, 5'd0, 1'b0, 1'b0});
    end

    run_op(8'd5,   8'h00, 0);   // all-zero multiplier
    run_op(8'hFD,  8'hFF, 1);   // all-one multiplier
    run_op(8'hFD,  8'h05, 3);   // -3 * 5
    run_op(8'h07,  8'hFC, 2);   // 7 * -4
    run_op(8'h80,  8'h80, 0);   // most negative operands
    for (int i = 0; i < 10; i++)
      run_op(N'($urandom), N'($urandom), int'($urandom_range(0, 3)));

    // Illegal address: immediate decode, err on the following edge, sticky
    @(negedge clk);
    force_en  = 1'b1;
    force_val = 5'd17;
    #1;
    check("illegal_decode",
          {22'd0, load_incr, upc_next, ld_m, ld_q, clr_a, add_en, sub_en, shift_en, done},
          {22'd0, 1'b1, 5'd0, 7'd0});
    check("err_before_edge", 32'(err), 32'd0);
    @(negedge clk);
    check("err_set", 32'(err), 32'd1);
    force_val = IDLE;
    repeat (4) @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);
    force_en = 1'b0;

    // Reset in the middle of an operation
    @(negedge clk);
    m_in  = 8'd3;
    q_in  = 8'd0;
    start = 1'b1;
    wait_upc(SHIFT, 50, "reach_shift");
    start = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("err_async_clear", 32'(err), 32'd0);
    force_en  = 1'b1;
    force_val = LOOP;
    #1;
    check("cnt_async_clear", 32'(load_incr), 32'd0);
    force_en = 1'b0;
    @(negedge clk);
    check("upc_in_reset", 32'(upc), 32'(IDLE));
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("abandoned_idle", {30'd0, upc == IDLE, done}, 32'h2);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("strobe_exclusive", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ucode_seq.md
UCODE_SEQ -- requirements
Module: ucode_seq

Interface
REQ-001 Parameter N, default 8, meaning multiplier operand width in bits; legal range 2..16.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 upc  input  5  current micro-address from the micro-PC register.
REQ-005 start  input  1  multiply request, synchronous to clk, level-sensitive.
REQ-006 q0  input  1  multiplier LSB from the datapath Q register.
REQ-007 load_incr  output  1  1 = micro-PC loads upc_next; 0 = micro-PC increments.
REQ-008 upc_next  output  5  branch target address.
REQ-009 ld_m, ld_q, clr_a, add_en, sub_en, shift_en  output  1 each  datapath strobes: load M, load Q, clear A, A<=A+M, A<=A-M, arithmetic right shift of A:Q.
REQ-010 busy  output  1  high at every upc except 0 and 9.
REQ-011 done  output  1  product valid.
REQ-012 err  output  1  sticky illegal-address flag.

Function
REQ-013 Microcode ROM and branch logic SHALL be combinational from upc, start, q0 and cnt, so the micro-PC sees the decision in the same cycle.
REQ-014 Iteration counter cnt, width $clog2(N), SHALL be the only datapath-style register in the block.
REQ-015 upc 0 IDLE: if start=0, load_incr=1 and upc_next=0; otherwise load_incr=0.
REQ-016 upc 1 LOAD: ld_m=ld_q=clr_a=1, cnt<=N-1 at the clock edge, and load_incr=0.
REQ-017 upc 2 TEST: if q0=0, load_incr=1 and upc_next=4; otherwise load_incr=0.
REQ-018 upc 3 ADD: add_en=1 and load_incr=0.
REQ-019 upc 4 SHIFT: shift_en=1, cnt<=cnt-1 at the clock edge, and load_incr=0.
REQ-020 upc 5 LOOP: if cnt!=0, load_incr=1 and upc_next=2; otherwise load_incr=0.
REQ-021 upc 6 FTEST: if q0=0, load_incr=1 and upc_next=8; otherwise load_incr=0.
REQ-022 upc 7 SUB: sub_en=1 and load_incr=0; this is the Robertson sign correction.
REQ-023 upc 8 FSHIFT: shift_en=1 and load_incr=0.
REQ-024 upc 9 DONE: done=1; if start=1, load_incr=1 and upc_next=9 (hold); otherwise load_incr=0.
REQ-025 upc 10 RET: load_incr=1 and upc_next=0.
REQ-026 upc 11..31 illegal: load_incr=1, upc_next=0, all strobes 0, err<=1 at the clock edge.
REQ-027 err SHALL clear only on reset.
REQ-028 When load_incr=0, upc_next SHALL be 0.
REQ-029 At most one of add_en, sub_en and shift_en SHALL be high in any cycle.
REQ-030 cnt SHALL hold its value except at upc 1 and upc 4.
REQ-031 cnt decrement at 0 SHALL wrap modulo 2^width; this is unreachable in legal flow.
REQ-032 Total shifts per operation SHALL equal N: N-1 in the loop plus 1 final.
REQ-033 A start held high through DONE SHALL NOT retrigger; a new operation requires start to return to 0 first.

Reset
REQ-034 On reset, cnt=0 and err=0 asynchronously.
REQ-035 While reset is asserted, outputs SHALL follow the decode of the upc input; the micro-PC register drives upc to 0 during reset, giving IDLE outputs.
REQ-036 Reset mid-operation SHALL abandon the operation with no partial done.

Structure
REQ-037 Shared package ucode_pkg SHALL hold the 5-bit address constants (IDLE=0 .. RET=10), the branch-condition enum (INCR, ALWAYS, IF_NSTART, IF_START, IF_Q0Z, IF_CNTNZ) and the microword struct (cond, target, six strobes, done).
REQ-038 Sub-module ucode_rom SHALL be a combinational upc-to-microword lookup; ucode_seq SHALL hold the branch evaluation, cnt and err.

Verification
REQ-039 Idle: N=8, start=0, upc=0 -> load_incr=1, upc_next=0, busy=0, done=0 every cycle.
REQ-040 All-zero multiplier: N=8, q0=0 throughout, closed loop with a micro-PC model -> upc reaches 9 exactly 24 cycles after upc=1, 8 shift_en pulses, 0 add_en, 0 sub_en.
REQ-041 All-one multiplier: N=8, q0=1 throughout -> upc reaches 9 exactly 32 cycles after upc=1, 7 add_en, 1 sub_en, 8 shift_en.
REQ-042 Full product: N=8, closed loop with a datapath model, M=-3, Q=5 -> product -15 (16'hFFF1); M=7, Q=-4 -> -28 (16'hFFE4).
REQ-043 Held start: start held high after done -> upc stays 9 with done=1; on start=0, upc goes 10 then 0, and no second LOAD occurs.
REQ-044 Illegal address and reset: force upc=17 -> upc_next=0, load_incr=1, err=1 next edge, err sticky; reset at upc=4 -> cnt=0, err=0 immediately.
